// File: rtl/data_cache_pkg.sv
// Shared geometry, FSM state type and address-field helpers for the direct-mapped data cache.
package data_cache_pkg;

  localparam int unsigned BLOCK_SIZE = 8;
  localparam int unsigned NUM_LINES  = 16;
  localparam int unsigned WIDTH      = 32;

  localparam int unsigned OFFSET_W = $clog2(BLOCK_SIZE);
  localparam int unsigned INDEX_W  = $clog2(NUM_LINES);
  localparam int unsigned TAG_W    = WIDTH - OFFSET_W - INDEX_W - 2;

  typedef enum logic [1:0] {
    StIdle,
    StWback,
    StRefill
  } state_e;

  function automatic logic [OFFSET_W-1:0] addr_offset(input logic [WIDTH-1:0] addr);
    return addr[OFFSET_W+1:2];
  endfunction

  function automatic logic [INDEX_W-1:0] addr_index(input logic [WIDTH-1:0] addr);
    return addr[OFFSET_W+INDEX_W+1:OFFSET_W+2];
  endfunction

  function automatic logic [TAG_W-1:0] addr_tag(input logic [WIDTH-1:0] addr);
    return addr[WIDTH-1:OFFSET_W+INDEX_W+2];
  endfunction

  // Block-aligned byte address; DRAM steps through the words itself.
  function automatic logic [WIDTH-1:0] block_addr(input logic [TAG_W-1:0]   tag,
                                                  input logic [INDEX_W-1:0] idx);
    return {tag, idx, (OFFSET_W + 2)'(0)};
  endfunction

endpackage

// File: rtl/data_cache_if.sv
// Core-side and DRAM-side signals of the data cache; the cache takes the slave modport.
interface data_cache_if
  import data_cache_pkg::*;
();

  logic [WIDTH-1:0] cpu_addr;
  logic             data_req;
  logic             wren;
  logic [WIDTH-1:0] cpu_wr_data;
  logic [WIDTH-1:0] cpu_rd_data;
  logic             hit;
  logic             ram_abort;

  logic             dram_wr_req;
  logic [WIDTH-1:0] dram_wr_addr;
  logic [WIDTH-1:0] dram_wr_data;
  logic             dram_wr_val;
  logic             dram_rd_req;
  logic [WIDTH-1:0] dram_rd_addr;
  logic [WIDTH-1:0] dram_rd_data;
  logic             dram_rd_val;

  modport slave (
    input  cpu_addr, data_req, wren, cpu_wr_data, dram_wr_val, dram_rd_data, dram_rd_val,
    output cpu_rd_data, hit, ram_abort, dram_wr_req, dram_wr_addr, dram_wr_data,
           dram_rd_req, dram_rd_addr
  );

  modport master (
    output cpu_addr, data_req, wren, cpu_wr_data, dram_wr_val, dram_rd_data, dram_rd_val,
    input  cpu_rd_data, hit, ram_abort, dram_wr_req, dram_wr_addr, dram_wr_data,
           dram_rd_req, dram_rd_addr
  );

endinterface

// File: rtl/cache_line_store.sv
// Line data, tag, valid and dirty storage: one asynchronous read port, one synchronous write port.
module cache_line_store
  import data_cache_pkg::*;
(
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [INDEX_W-1:0]  rd_idx_i,
  input  logic [OFFSET_W-1:0] rd_off_i,
  output logic [WIDTH-1:0]    rd_word_o,
  output logic [TAG_W-1:0]    rd_tag_o,
  output logic                rd_valid_o,
  output logic                rd_dirty_o,
  input  logic                we_i,
  input  logic [INDEX_W-1:0]  wr_idx_i,
  input  logic [OFFSET_W-1:0] wr_off_i,
  input  logic [WIDTH-1:0]    wr_data_i,
  input  logic                set_dirty_i,
  input  logic                clr_dirty_i,
  input  logic                fill_i,
  input  logic [TAG_W-1:0]    fill_tag_i
);

  logic [WIDTH-1:0] data_q [NUM_LINES][BLOCK_SIZE];
  logic [TAG_W-1:0] tag_q  [NUM_LINES];
  logic [NUM_LINES-1:0] valid_q;
  logic [NUM_LINES-1:0] dirty_q;

  assign rd_word_o  = data_q[rd_idx_i][rd_off_i];
  assign rd_tag_o   = tag_q[rd_idx_i];
  assign rd_valid_o = valid_q[rd_idx_i];
  assign rd_dirty_o = dirty_q[rd_idx_i];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else begin
      if (set_dirty_i) dirty_q[wr_idx_i] <= 1'b1;
      if (clr_dirty_i) dirty_q[wr_idx_i] <= 1'b0;
      if (fill_i) begin
        valid_q[wr_idx_i] <= 1'b1;
        dirty_q[wr_idx_i] <= 1'b0;
      end
    end
  end

  // Data and tags are never reset; valid gates their use.
  always_ff @(posedge clk_i) begin
    if (we_i)   data_q[wr_idx_i][wr_off_i] <= wr_data_i;
    if (fill_i) tag_q[wr_idx_i] <= fill_tag_i;
  end

endmodule

// File: rtl/data_cache.sv
// Write-back, write-allocate, direct-mapped data cache with burst write-back and refill FSM.
module data_cache
  import data_cache_pkg::*;
(
  input  logic         clock,
  input  logic         rst,
  data_cache_if.slave  bus
);

  state_e              state_q, state_d;
  logic [OFFSET_W-1:0] cnt_q, cnt_d;
  logic [INDEX_W-1:0]  miss_idx_q, miss_idx_d;
  logic [TAG_W-1:0]    miss_tag_q, miss_tag_d;
  logic [TAG_W-1:0]    victim_tag_q, victim_tag_d;

  logic [INDEX_W-1:0]  cpu_idx;
  logic [OFFSET_W-1:0] cpu_off;
  logic [TAG_W-1:0]    cpu_tag;

  logic [INDEX_W-1:0]  rd_idx;
  logic [OFFSET_W-1:0] rd_off;
  logic [WIDTH-1:0]    rd_word;
  logic [TAG_W-1:0]    rd_tag;
  logic                rd_valid, rd_dirty;

  logic                we, set_dirty, clr_dirty, fill;
  logic [INDEX_W-1:0]  wr_idx;
  logic [OFFSET_W-1:0] wr_off;
  logic [WIDTH-1:0]    wr_data;
  logic                hit;
  logic                last_word;

  assign cpu_idx = addr_index(bus.cpu_addr);
  assign cpu_off = addr_offset(bus.cpu_addr);
  assign cpu_tag = addr_tag(bus.cpu_addr);

  // The lookup port follows the core in IDLE and the latched victim line during bursts.
  assign rd_idx = (state_q == StIdle) ? cpu_idx : miss_idx_q;
  assign rd_off = (state_q == StIdle) ? cpu_off : cnt_q;

  cache_line_store u_store (
    .clk_i       (clock),
    .rst_i       (rst),
    .rd_idx_i    (rd_idx),
    .rd_off_i    (rd_off),
    .rd_word_o   (rd_word),
    .rd_tag_o    (rd_tag),
    .rd_valid_o  (rd_valid),
    .rd_dirty_o  (rd_dirty),
    .we_i        (we),
    .wr_idx_i    (wr_idx),
    .wr_off_i    (wr_off),
    .wr_data_i   (wr_data),
    .set_dirty_i (set_dirty),
    .clr_dirty_i (clr_dirty),
    .fill_i      (fill),
    .fill_tag_i  (miss_tag_q)
  );

  assign hit       = (state_q == StIdle) && bus.data_req && rd_valid && (rd_tag == cpu_tag);
  assign last_word = (cnt_q == OFFSET_W'(BLOCK_SIZE - 1));

  assign bus.hit          = hit;
  assign bus.ram_abort    = bus.data_req && !hit;
  assign bus.cpu_rd_data  = hit ? rd_word : '0;
  assign bus.dram_wr_req  = (state_q == StWback);
  assign bus.dram_wr_addr = block_addr(victim_tag_q, miss_idx_q);
  assign bus.dram_wr_data = rd_word;
  assign bus.dram_rd_req  = (state_q == StRefill);
  assign bus.dram_rd_addr = block_addr(miss_tag_q, miss_idx_q);

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    miss_idx_d   = miss_idx_q;
    miss_tag_d   = miss_tag_q;
    victim_tag_d = victim_tag_q;
    we           = 1'b0;
    set_dirty    = 1'b0;
    clr_dirty    = 1'b0;
    fill         = 1'b0;
    wr_idx       = cpu_idx;
    wr_off       = cpu_off;
    wr_data      = bus.cpu_wr_data;

    unique case (state_q)
      StIdle: begin
        if (hit && bus.wren) begin
          we        = 1'b1;
          set_dirty = 1'b1;
        end else if (bus.data_req && !hit) begin
          miss_idx_d   = cpu_idx;
          miss_tag_d   = cpu_tag;
          victim_tag_d = rd_tag;
          cnt_d        = '0;
          state_d      = (rd_valid && rd_dirty) ? StWback : StRefill;
        end
      end
      StWback: begin
        wr_idx = miss_idx_q;
        if (bus.dram_wr_val) begin
          cnt_d = cnt_q + OFFSET_W'(1);
          if (last_word) begin
            clr_dirty = 1'b1;
            cnt_d     = '0;
            state_d   = StRefill;
          end
        end
      end
      StRefill: begin
        wr_idx  = miss_idx_q;
        wr_off  = cnt_q;
        wr_data = bus.dram_rd_data;
        if (bus.dram_rd_val) begin
          we    = 1'b1;
          cnt_d = cnt_q + OFFSET_W'(1);
          if (last_word) begin
            fill    = 1'b1;
            cnt_d   = '0;
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock) begin
    if (rst) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      miss_idx_q   <= '0;
      miss_tag_q   <= '0;
      victim_tag_q <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      miss_idx_q   <= miss_idx_d;
      miss_tag_q   <= miss_tag_d;
      victim_tag_q <= victim_tag_d;
    end
  end

endmodule

// File: tb/tb_data_cache.sv
// Directed bench for data_cache: cold miss, write hit, dirty eviction, gapped refill, reset, idle vals.
module tb_data_cache;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  data_cache_if bus ();

  data_cache dut (
    .clock (clk),
    .rst   (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic access(input logic [31:0] addr, input logic wr, input logic [31:0] wdata);
    bus.cpu_addr    = addr;
    bus.data_req    = 1'b1;
    bus.wren        = wr;
    bus.cpu_wr_data = wdata;
    #1;
  endtask

  // Supplies one refill burst of base+i with a gap of idle cycles between vals.
  task automatic refill(input logic [31:0] base, input int gap);
    for (int i = 0; i < 8; i++) begin
      bus.dram_rd_data = base + 32'(i);
      bus.dram_rd_val  = 1'b1;
      #1;
      chk("refill_abort", {31'b0, bus.ram_abort}, 32'd1);
      tick();
      bus.dram_rd_val = 1'b0;
      if (i < 7) begin
        for (int g = 0; g < gap; g++) begin
          chk("gap_abort", {31'b0, bus.ram_abort}, 32'd1);
          chk("gap_hit", {31'b0, bus.hit}, 32'd0);
          tick();
        end
      end
    end
  endtask

  logic [31:0] wb_exp [8];

  initial begin
    total = 0;
    bad   = 0;
    rst             = 1'b1;
    bus.cpu_addr    = '0;
    bus.data_req    = 1'b0;
    bus.wren        = 1'b0;
    bus.cpu_wr_data = '0;
    bus.dram_wr_val = 1'b0;
    bus.dram_rd_val = 1'b0;
    bus.dram_rd_data = '0;
    repeat (5) tick();
    chk("rst_rd_req", {31'b0, bus.dram_rd_req}, 32'd0);
    chk("rst_wr_req", {31'b0, bus.dram_wr_req}, 32'd0);
    chk("rst_abort", {31'b0, bus.ram_abort}, 32'd0);
    rst = 1'b0;
    tick();

    // Cold read miss at 0x100.
    access(32'h100, 1'b0, 32'h0);
    chk("cold_abort", {31'b0, bus.ram_abort}, 32'd1);
    chk("cold_hit", {31'b0, bus.hit}, 32'd0);
    chk("cold_rdata0", bus.cpu_rd_data, 32'h0);
    tick();
    chk("cold_rd_req", {31'b0, bus.dram_rd_req}, 32'd1);
    chk("cold_rd_addr", bus.dram_rd_addr, 32'h100);
    chk("cold_wr_req", {31'b0, bus.dram_wr_req}, 32'd0);
    refill(32'hA0, 0);
    chk("cold_hit_after", {31'b0, bus.hit}, 32'd1);
    chk("cold_rdata", bus.cpu_rd_data, 32'hA0);
    chk("cold_abort_after", {31'b0, bus.ram_abort}, 32'd0);
    chk("cold_rd_req_off", {31'b0, bus.dram_rd_req}, 32'd0);
    access(32'h11C, 1'b0, 32'h0);
    chk("read_11c", bus.cpu_rd_data, 32'hA7);
    chk("read_11c_abort", {31'b0, bus.ram_abort}, 32'd0);
    tick();

    // Write hit then read back.
    access(32'h104, 1'b1, 32'hDEAD);
    chk("wr_hit", {31'b0, bus.hit}, 32'd1);
    chk("wr_abort", {31'b0, bus.ram_abort}, 32'd0);
    tick();
    access(32'h104, 1'b0, 32'h0);
    chk("wr_readback", bus.cpu_rd_data, 32'hDEAD);
    chk("wr_no_wb", {31'b0, bus.dram_wr_req}, 32'd0);
    tick();

    // Dirty eviction: 0x300 shares index 8 with 0x100.
    access(32'h300, 1'b0, 32'h0);
    chk("evict_abort", {31'b0, bus.ram_abort}, 32'd1);
    tick();
    chk("evict_wr_req", {31'b0, bus.dram_wr_req}, 32'd1);
    chk("evict_wr_addr", bus.dram_wr_addr, 32'h100);
    chk("evict_no_rd", {31'b0, bus.dram_rd_req}, 32'd0);
    for (int i = 0; i < 8; i++) wb_exp[i] = 32'hA0 + 32'(i);
    wb_exp[1] = 32'hDEAD;
    tick();
    chk("evict_hold", bus.dram_wr_data, 32'hA0);
    for (int i = 0; i < 8; i++) begin
      chk("evict_data", bus.dram_wr_data, wb_exp[i]);
      bus.dram_wr_val = 1'b1;
      tick();
      bus.dram_wr_val = 1'b0;
    end
    #1;
    chk("evict_wr_done", {31'b0, bus.dram_wr_req}, 32'd0);
    chk("evict_rd_req", {31'b0, bus.dram_rd_req}, 32'd1);
    chk("evict_rd_addr", bus.dram_rd_addr, 32'h300);

    // Refill with 3-cycle gaps between vals.
    refill(32'hB0, 3);
    for (int i = 0; i < 8; i++) begin
      access(32'h300 + 32'(4 * i), 1'b0, 32'h0);
      chk("gap_word", bus.cpu_rd_data, 32'hB0 + 32'(i));
    end
    access(32'h100, 1'b0, 32'h0);
    chk("old_tag_miss", {31'b0, bus.hit}, 32'd0);
    bus.data_req = 1'b0;
    tick();
    chk("no_miss_taken", {31'b0, bus.dram_rd_req}, 32'd0);

    // Clean miss to 0x500 goes straight to refill; reset after 4 vals.
    access(32'h500, 1'b0, 32'h0);
    tick();
    chk("clean_no_wb", {31'b0, bus.dram_wr_req}, 32'd0);
    chk("clean_rd_addr", bus.dram_rd_addr, 32'h500);
    for (int i = 0; i < 4; i++) begin
      bus.dram_rd_data = 32'hE0 + 32'(i);
      bus.dram_rd_val  = 1'b1;
      tick();
    end
    bus.dram_rd_val = 1'b0;
    chk("mid_rd_req", {31'b0, bus.dram_rd_req}, 32'd1);
    rst = 1'b1;
    tick();
    chk("rst_mid_rd_req", {31'b0, bus.dram_rd_req}, 32'd0);
    rst = 1'b0;
    access(32'h300, 1'b0, 32'h0);
    chk("rst_invalid", {31'b0, bus.hit}, 32'd0);
    bus.data_req = 1'b0;
    tick();

    // Fill 0x040 (index 2), then pulse vals while idle.
    access(32'h040, 1'b0, 32'h0);
    tick();
    chk("l2_rd_addr", bus.dram_rd_addr, 32'h040);
    refill(32'hC0, 1);
    chk("l2_rdata", bus.cpu_rd_data, 32'hC0);
    bus.data_req = 1'b0;
    bus.dram_rd_data = 32'hFF;
    bus.dram_rd_val  = 1'b1;
    bus.dram_wr_val  = 1'b1;
    repeat (3) tick();
    bus.dram_rd_val = 1'b0;
    bus.dram_wr_val = 1'b0;
    chk("idle_val_rd_req", {31'b0, bus.dram_rd_req}, 32'd0);
    access(32'h040, 1'b0, 32'h0);
    chk("idle_val_hit", {31'b0, bus.hit}, 32'd1);
    chk("idle_val_w0", bus.cpu_rd_data, 32'hC0);
    access(32'h05C, 1'b0, 32'h0);
    chk("idle_val_w7", bus.cpu_rd_data, 32'hC7);
    bus.data_req = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
